// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed common-anode 7-segment scanner with hex decode, LZB, guard and PWM
module seg7_scan #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 12500,
  parameter int BLANK    = 64,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   iDIG,
  input  logic [DIGITS-1:0]     iDP,
  input  logic                  iLZB,
  input  logic                  iEN,
  input  logic [BRIGHT_W-1:0]   iBRIGHT,
  output logic [6:0]            oSEG,
  output logic                  oDP,
  output logic [DIGITS-1:0]     oAN,
  output logic                  oFRAME
);
  localparam int CW = $clog2(DIV);
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [4*DIGITS-1:0]   sdig_q, sdig_d;
  logic [DIGITS-1:0]     sdp_q, sdp_d;
  logic                  slzb_q, slzb_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q, frame_d;
  logic                  snap, wrap, on, blank;
  logic [3:0]            nib;
  // Next-state: counters, snapshot bypass (digit 0 shows the fresh capture) and registered outputs
  always_comb begin
    snap    = cnt_q == '0 && dig_q == '0;
    wrap    = cnt_q == CW'(DIV - 1);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    dig_d   = !wrap ? dig_q : (dig_q == DW'(DIGITS - 1) ? '0 : dig_q + 1'b1);
    sdig_d  = snap ? iDIG : sdig_q;
    sdp_d   = snap ? iDP : sdp_q;
    slzb_d  = snap ? iLZB : slzb_q;
    nib     = sdig_d[{dig_q, 2'b00} +: 4];
    blank   = slzb_d && dig_q != '0 && (sdig_d >> {dig_q, 2'b00}) == '0;
    on      = iEN && cnt_q >= CW'(BLANK) && (&iBRIGHT || cnt_q[BRIGHT_W-1:0] < iBRIGHT);
    seg_d   = blank ? 7'h7F : GLYPH[nib];
    dp_d    = ~sdp_d[dig_q];
    an_d    = on ? ~(DIGITS'(1) << dig_q) : '1;
    frame_d = snap;
  end
  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      sdig_q  <= '0;
      sdp_q   <= '0;
      slzb_q  <= 1'b0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      sdig_q  <= sdig_d;
      sdp_q   <= sdp_d;
      slzb_q  <= slzb_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end
  assign oSEG   = seg_q;
  assign oDP    = dp_q;
  assign oAN    = an_q;
  assign oFRAME = frame_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized bench for seg7_scan against a cycle-count based reference model
module tb_seg7_scan;
  localparam int DIGITS = 4, DIV = 32, BLANK = 4, BW = 4;
  logic clk = 0, reset = 1;
  logic [15:0] iDIG;
  logic [3:0]  iDP;
  logic        iLZB, iEN;
  logic [3:0]  iBRIGHT;
  logic [6:0]  oSEG;
  logic        oDP;
  logic [3:0]  oAN;
  logic        oFRAME;
  int passed = 0, total = 0, cyc = 0;
  always #5 clk = ~clk;
  seg7_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK), .BRIGHT_W(BW)) dut (
    .clk(clk), .reset(reset), .iDIG(iDIG), .iDP(iDP), .iLZB(iLZB), .iEN(iEN),
    .iBRIGHT(iBRIGHT), .oSEG(oSEG), .oDP(oDP), .oAN(oAN), .oFRAME(oFRAME)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
  endtask
  // Reference model: position in the scan is derived purely from the cycle count since reset
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int k = 0, mc, md;
  logic [15:0] m_dig = 0;
  logic [3:0]  m_dp = 0;
  logic        m_lzb = 0;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame;
  logic [3:0]  e_an;
  bit          valid = 0;
  always @(posedge clk) begin
    if (reset) begin
      k = 0; m_dig = 0; m_dp = 0; m_lzb = 0;
      e_seg = 7'h7F; e_dp = 1; e_an = 4'hF; e_frame = 0;
    end else begin
      mc = k % DIV;
      md = (k / DIV) % DIGITS;
      if (mc == 0 && md == 0) begin m_dig = iDIG; m_dp = iDP; m_lzb = iLZB; end
      e_frame = mc == 0 && md == 0;
      e_seg = glyph[m_dig[4*md +: 4]];
      if (m_lzb && md > 0 && (m_dig >> (4 * md)) == 0) e_seg = 7'h7F;
      e_dp = !m_dp[md];
      e_an = (iEN && mc >= BLANK && (iBRIGHT == 4'hF || (mc % 16) < iBRIGHT)) ? ~(4'b1 << md) : 4'hF;
      k++;
    end
    valid = 1;
  end
  logic [6:0] prev_seg;
  bit prev_on = 0;
  always @(negedge clk) if (valid) begin
    chk("model_seg", 32'(oSEG), 32'(e_seg));
    chk("model_dp", 32'(oDP), 32'(e_dp));
    chk("model_an", 32'(oAN), 32'(e_an));
    chk("model_frame", 32'(oFRAME), 32'(e_frame));
    chk("one_anode_max", 32'($countones(~oAN) <= 1), 32'd1);
    if (prev_on && oAN != 4'hF) chk("seg_stable_while_lit", 32'(oSEG), 32'(prev_seg));
    prev_on = oAN != 4'hF;
    prev_seg = oSEG;
  end
  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask
  task automatic go(input int c);
    while (cyc < c) step();
  endtask
  task automatic pin(input string name, input logic [3:0] an, input logic [6:0] seg);
    chk({name, "_an"}, 32'(oAN), 32'(an));
    chk({name, "_seg"}, 32'(oSEG), 32'(seg));
  endtask
  initial begin
    bit bad;
    iDIG = 16'h1234; iDP = 0; iLZB = 0; iEN = 1; iBRIGHT = 4'hF;
    repeat (3) @(posedge clk);
    #1 reset = 0; cyc = 0;
    go(1);   chk("frame_first", 32'(oFRAME), 32'd1);
    go(4);   chk("guard_off", 32'(oAN), 32'hF);
    go(5);   pin("scan_d0_start", 4'b1110, 7'h19);
    go(32);  pin("scan_d0_end", 4'b1110, 7'h19);
    go(37);  pin("scan_d1", 4'b1101, 7'h30);
    go(69);  pin("scan_d2", 4'b1011, 7'h24);
    go(101); pin("scan_d3", 4'b0111, 7'h79);
    go(128); chk("frame_gap", 32'(oFRAME), 32'd0);
    go(129); chk("frame_second", 32'(oFRAME), 32'd1);
    go(140); iDIG = 16'hABCD;
    go(170); pin("tear_d1", 4'b1101, 7'h30);
    go(230); pin("tear_d3", 4'b0111, 7'h79);
    go(262); pin("new_d0", 4'b1110, 7'h21);
    go(300); pin("new_d1", 4'b1101, 7'h46);
    go(340); pin("new_d2", 4'b1011, 7'h03);
    go(370); pin("new_d3", 4'b0111, 7'h08);
    go(380); iDIG = 16'h0050; iLZB = 1; iDP = 4'b0100;
    go(390); pin("lzb_d0", 4'b1110, 7'h40); chk("lzb_d0_dp", 32'(oDP), 32'd1);
    go(425); pin("lzb_d1", 4'b1101, 7'h12);
    go(457); pin("lzb_d2", 4'b1011, 7'h7F); chk("lzb_d2_dp", 32'(oDP), 32'd0);
    go(489); pin("lzb_d3", 4'b0111, 7'h7F);
    go(500); iDIG = 16'h0000;
    go(521); pin("zero_d0", 4'b1110, 7'h40);
    go(553); pin("zero_d1", 4'b1101, 7'h7F);
    go(585); pin("zero_d2", 4'b1011, 7'h7F);
    go(617); pin("zero_d3", 4'b0111, 7'h7F);
    go(640); iBRIGHT = 0;
    go(641);
    bad = 0;
    repeat (64) begin bad |= oAN != 4'hF; step(); end
    chk("bright0_dark", 32'(bad), 32'd0);
    go(710); iBRIGHT = 4'd4;
    go(754); chk("bright4_on", 32'(oAN), 32'b0111);
    go(758); chk("bright4_off", 32'(oAN), 32'hF);
    go(760); iBRIGHT = 4'hF;
    go(780); chk("en_before", 32'(oAN), 32'b1110);
    iEN = 0; step(); step();
    chk("en_fall_dark", 32'(oAN), 32'hF);
    iEN = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) begin
        iDIG = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(4)));
        iDP = 4'($urandom); iLZB = 1'($urandom);
      end
      if ($urandom_range(49) == 0) iEN = ~iEN;
      if ($urandom_range(29) == 0) iBRIGHT = 4'($urandom);
      step();
    end
    iEN = 1; iBRIGHT = 4'hF;
    while (((cyc - 1) % 128) != 70) step();
    reset = 1; step();
    chk("rst_an", 32'(oAN), 32'hF);
    chk("rst_seg", 32'(oSEG), 32'h7F);
    chk("rst_dp", 32'(oDP), 32'd1);
    chk("rst_frame", 32'(oFRAME), 32'd0);
    reset = 0; cyc = 0;
    step(); chk("rst_frame_after", 32'(oFRAME), 32'd1);
    go(5);  chk("rst_restart_d0", 32'(oAN), 32'b1110);
    go(300);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for a common-anode bank of DIGITS seven-segment indicators. It takes a packed hex word with per-digit decimal points and scans one digit at a time. Features:
- Built-in hex glyph decode.
- Leading-zero blanking.
- Anti-ghosting guard interval.
- PWM brightness control.

It sits between the debug or status registers and the board's segment and anode pins, replacing per-digit static decoders where pins are shared.

## Interface
Clocking: one clock, `clk`; reset is synchronous and active-high, `reset`.

Parameters:
- DIGITS, 4, number of indicators scanned (≥1).
- DIV, 12500, clocks per digit slot (must exceed BLANK + 2^BRIGHT_W).
- BLANK, 64, guard clocks at the start of each slot during which all anodes are off (≥1).
- BRIGHT_W, 4, width of the brightness control.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- iDIG  in  4*DIGITS  hex nibbles; digit 0 = iDIG[3:0] (rightmost), digit DIGITS-1 is most significant.
- iDP  in  DIGITS  decimal point per digit, 1 = lit.
- iLZB  in  1  leading-zero blanking enable.
- iEN  in  1  display enable; 0 = all anodes off, counters keep running.
- iBRIGHT  in  BRIGHT_W  duty setting; 0 = dark, all-ones = 100 %.
- oSEG  out  7  segments, active-low, bit0 = a (top) … bit6 = g (middle).
- oDP  out  1  decimal point, active-low.
- oAN  out  DIGITS  digit select, active-low, at most one bit low at any time.
- oFRAME  out  1  one-clock pulse at each frame start.

## Operation
- **Slot counter.** `cnt` counts 0..DIV-1.
- **Digit index.** `dig` counts 0..DIGITS-1. It advances when `cnt` wraps, and itself wraps from DIGITS-1 to 0.
- **Snapshot.** On every cycle with `dig`=0 and `cnt`=0, including the first cycle after reset, iDIG, iDP and iLZB are captured into shadow registers. The whole frame is displayed from the shadow registers, so there is no tearing.
- **Glyphs.** Active-low hex values, 0..F: 40 79 24 30 19 12 02 78 00 18 08 03 46 21 06 0E.
- **Leading-zero blanking.** With shadow LZB=1, digit i > 0 is blanked (oSEG = 7F) when shadow nibbles DIGITS-1 down to i are all zero. Digit 0 is never blanked. The DP of a blanked digit is still driven from iDP.
- **Anode on condition.** The anode for `dig` is driven low only when all of the following hold:
  - iEN = 1;
  - `cnt` ≥ BLANK;
  - iBRIGHT = all-ones, or `cnt`[BRIGHT_W-1:0] < iBRIGHT.
  
  Otherwise oAN = all-ones.
- **Live inputs.** iBRIGHT and iEN are sampled live; they are not snapshotted.
- **Reset values.** oAN = all-ones, oSEG = 7F, oDP = 1, oFRAME = 0; counters and shadow registers = 0.

## Timing
- All outputs are registered and reflect the counter and shadow state of the previous cycle (1-cycle pipeline).
- Frame length is DIGITS*DIV clocks. oFRAME is high exactly one cycle per frame, in the cycle after the snapshot load.
- oSEG/oDP change only while the guard is active: the new digit's glyph is present from the first guard cycle. Segments never change while an anode is low.
- Input latency: a change on iDIG/iDP/iLZB is visible no later than one frame + 2 clocks later.
- iEN falling: oAN = all-ones on the next-but-one edge, with no partial-digit glitch afterwards.
- iBRIGHT change: takes effect within 2 clocks.
- Reset asserted mid-slot: the next edge gives reset values. After release, scanning restarts at digit 0 with a fresh snapshot.
- DIGITS = 1: `dig` is constant 0, and a snapshot is taken every DIV clocks.

## Test plan
Benches use DIGITS=4, DIV=32, BLANK=4, BRIGHT_W=4.
- **Basic scan.** Reset, then iDIG=1234, iDP=0, iEN=1, iBRIGHT=F. Required: oAN = 1110 with oSEG = 19 for cycles 5..32 after release, then 1101/30, 1011/24, 0111/79. oFRAME pulses every 128 clocks.
- **Leading-zero blanking.** iDIG=0050, iLZB=1, iDP=0100. Required:
  - digit 3: oSEG = 7F;
  - digit 2: oSEG = 7F, oDP = 0;
  - digit 1: oSEG = 12;
  - digit 0: oSEG = 40.
  
  With iDIG=0000 only digit 0 shows 40.
- **Snapshot / no tearing.** Change iDIG from 1234 to ABCD mid-frame. Required: the rest of that frame still shows 1,2,3,4. The next frame shows D, C, b, A (21, 46, 03, 08).
- **Brightness.** iBRIGHT=4. Required: within each slot the anode is low only where `cnt` ≥ 4 and `cnt`[3:0] < 4. iBRIGHT=0 gives oAN = all-ones throughout.
- **Enable and guard.** Toggle iEN. Required: oAN = 1111 two clocks after iEN falls. Assert at every cycle that at most one anode is low, and that oSEG is stable while any anode is low.
- **Reset mid-operation.** Assert reset for 1 clock in digit 2. Required: reset values on the next edge, then the scan restarts at digit 0 with oFRAME one cycle after release.
